// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings and fetch-controller state type shared by the
// core-side blocks that talk to the instruction/data RAM.
//   OP_MVI / OP_LD / OP_ST  : 5-bit opcodes held in instr[OPCODE_MSB:OPCODE_LSB]
//   fetch_state_t           : states of the RAM fetch/arbitration controller
package cpu_pkg;

  localparam logic [4:0] OP_MVI = 5'b00001;
  localparam logic [4:0] OP_LD  = 5'b00100;
  localparam logic [4:0] OP_ST  = 5'b00101;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;

  typedef enum logic [2:0] {
    S_ISSUE,
    S_INSTR,
    S_IMM,
    S_HOLD,
    S_DWAIT
  } fetch_state_t;

endpackage

// File: rtl/ram_fetch_ctrl.sv
// ram_fetch_ctrl: initiator of the single-port instruction/data RAM.
// Fetches instruction words from the PC, gathers the trailing immediate word
// of mvi, presents {instr, imm} to the decode stage on a valid/ready
// handshake, and slots core load/store requests onto the same RAM port while
// the RAM is idle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_wr_en/mem_addr/mem_wdata    RAM request (read every cycle, 1-cycle latency)
//   mem_rdata                       RAM read data
//   instr_valid/instr_ready         instruction handshake to the core
//   instr/imm/instr_pc              fetched instruction, immediate, its address
//   redirect_valid/redirect_pc      branch taken: flush and refetch
//   d_req/d_we/d_addr/d_wdata       core load/store request (held until d_done)
//   d_done/d_rdata                  access-complete pulse, load data
module ram_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata
);

  fetch_state_t      state_q, state_d;
  fetch_state_t      ret_q, ret_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              d_accept;
  logic              is_mvi;

  assign is_mvi = (mem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_MVI);

  // A data access may only start while the RAM port is idle. A redirect in
  // the same cycle wins; the held d_req is then taken on the next cycle.
  // Gating with rst_n keeps mem_wr_en low for the whole reset interval.
  assign d_accept = rst_n && d_req && !redirect_valid &&
                    ((state_q == S_ISSUE) || (state_q == S_HOLD));

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    instr_pc_d = instr_pc_q;
    mem_addr   = pc_q;
    mem_wr_en  = 1'b0;

    unique case (state_q)
      S_ISSUE: begin
        // mem_addr already carries pc: this cycle is the fetch read.
        state_d = S_INSTR;
      end
      S_INSTR: begin
        instr_d    = mem_rdata;
        instr_pc_d = pc_q;
        pc_d       = pc_q + 1'b1;
        if (is_mvi) begin
          // Immediate sits in the next word; the address wraps with the PC.
          mem_addr = pc_q + 1'b1;
          state_d  = S_IMM;
        end else begin
          imm_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_IMM: begin
        imm_d   = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) state_d = S_ISSUE;
      end
      S_DWAIT: begin
        state_d = ret_q;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase

    // Load/store preempts both the fetch issue and the handshake.
    if (d_accept) begin
      mem_addr  = d_addr;
      mem_wr_en = d_we;
      ret_d     = state_q;
      state_d   = S_DWAIT;
    end

    // Redirect flushes everything fetched or in flight. In S_DWAIT the data
    // access still completes; only the return target changes.
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      state_d    = S_ISSUE;
      ret_d      = S_ISSUE;
      instr_d    = instr_q;
      imm_d      = imm_q;
      instr_pc_d = instr_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ISSUE;
      ret_q      <= S_ISSUE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      imm_q      <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_wdata   = d_wdata;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign imm         = imm_q;
  assign instr_pc    = instr_pc_q;
  assign d_done      = (state_q == S_DWAIT);
  assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_ram_fetch_ctrl.sv
module tb_ram_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [9:0]  instr_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [9:0]  pc;
  } iexp_t;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
  } dexp_t;

  iexp_t iq[$];
  dexp_t dq[$];
  iexp_t ie;
  dexp_t de;

  always #5 clk = ~clk;

  ram_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .imm            (imm),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_done         (d_done),
    .d_rdata        (d_rdata)
  );

  // Single-port RAM with registered read, preloaded on the first clock.
  logic [31:0] ram [1024];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[0]    <= 32'h08000020;
      ram[1]    <= 32'h12345678;
      ram[2]    <= 32'h10000002;
      ram[3]    <= 32'h10000003;
      ram[4]    <= 32'h10001841;
      ram[5]    <= 32'h08000000;
      ram[6]    <= 32'h00000066;
      ram[29]   <= 32'h1000001D;
      ram[1023] <= 32'h766E2C96;
      ram_init  <= 1'b1;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (no response within cycle budget)", name);
  endtask

  // Scoreboard monitor: instruction handshakes and data completions.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (iq.size() == 0) begin
        chk("instr_unexpected_handshake", 32'(instr_pc), 32'h0000FFFF);
      end else begin
        ie = iq.pop_front();
        chk("sb_instr", instr, ie.instr);
        chk("sb_imm", imm, ie.imm);
        chk("sb_instr_pc", 32'(instr_pc), 32'(ie.pc));
      end
    end
    if (rst_n && d_done) begin
      if (dq.size() == 0) begin
        chk("d_done_unexpected", 32'(d_done), 32'h0);
      end else begin
        de = dq.pop_front();
        if (de.is_load) chk("sb_d_rdata", d_rdata, de.data);
      end
    end
    if (mem_wr_en) wr_cnt++;
  end

  // Counts rising edges until instr_valid is seen; caller compares latency.
  task automatic wait_valid(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (instr_valid) return;
    end
    fail("wait_instr_valid");
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  task automatic push_i(input logic [31:0] i, input logic [31:0] m, input logic [9:0] p);
    iq.push_back('{instr: i, imm: m, pc: p});
  endtask

  task automatic d_access(input bit we, input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input bit redir, input logic [9:0] rpc);
    int n;
    bit seen;
    dq.push_back('{is_load: !we, data: exp_rd});
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (d_done) seen = 1'b1;
    end
    if (!seen) fail("wait_d_done");
    else chk("d_done_latency", 32'(n), 32'd1);
    if (redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc;
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    int w0;
    logic [31:0] s_instr, s_imm, s_pc, s_addr;

    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    d_req          = 1'b0;
    d_we           = 1'b0;
    d_addr         = '0;
    d_wdata        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_d_done", 32'(d_done), 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // 1: mvi at 0 with immediate at 1
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_i(32'h08000020, 32'h12345678, 10'd0);
    wait_valid(n);
    chk("mvi_latency", 32'(n), 32'd3);
    chk("mvi_next_pc", 32'(mem_addr), 32'd2);
    accept();

    // 2: plain instructions, 2-cycle latency after issue
    push_i(32'h10000002, 32'h0, 10'd2);
    wait_valid(n);
    chk("add_latency_pc2", 32'(n), 32'd2);
    accept();
    push_i(32'h10000003, 32'h0, 10'd3);
    wait_valid(n);
    accept();
    wait_valid(n);
    chk("add_latency_pc4", 32'(n), 32'd2);
    chk("add_instr", instr, 32'h10001841);
    chk("add_imm", imm, 32'h0);
    chk("add_next_pc", 32'(mem_addr), 32'd5);

    // 3: stall in S_HOLD
    s_instr = instr; s_imm = imm; s_pc = 32'(instr_pc); s_addr = 32'(mem_addr);
    w0 = wr_cnt;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_instr", instr, s_instr);
      chk("hold_imm", imm, s_imm);
      chk("hold_pc", 32'(instr_pc), s_pc);
      chk("hold_addr", 32'(mem_addr), s_addr);
    end
    chk("hold_no_write", 32'(wr_cnt - w0), 32'd0);

    // 4: load / store / reload while holding pc 4
    d_access(1'b0, 10'd1023, 32'h0, 32'h766E2C96, 1'b0, 10'd0);
    chk("after_load_valid", 32'(instr_valid), 32'h1);
    chk("after_load_instr", instr, 32'h10001841);
    w0 = wr_cnt;
    d_access(1'b1, 10'd438, 32'hDEADBEEF, 32'h0, 1'b0, 10'd0);
    chk("store_write_count", 32'(wr_cnt - w0), 32'd1);
    d_access(1'b0, 10'd438, 32'h0, 32'hDEADBEEF, 1'b0, 10'd0);
    push_i(32'h10001841, 32'h0, 10'd4);
    accept();

    // 5: redirect while in S_IMM of the mvi at 5
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'd29;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_valid(n);
    chk("redir_latency", 32'(n), 32'd2);
    chk("redir_instr_pc", 32'(instr_pc), 32'd29);
    chk("redir_instr", instr, 32'h1000001D);

    // Prepare wrap test data; second store redirects during S_DWAIT.
    d_access(1'b1, 10'd1023, 32'h08000007, 32'h0, 1'b0, 10'd0);
    d_access(1'b1, 10'd0, 32'hAAAA5555, 32'h0, 1'b1, 10'd29);
    wait_valid(n);
    chk("dwait_redir_latency", 32'(n), 32'd2);
    // Redirect together with instr_ready: no handshake may be taken.
    push_i(32'h1000001D, 32'h0, 10'd29);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'd29;
    @(posedge clk); #1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("redir_drops_valid", 32'(instr_valid), 32'h0);
    wait_valid(n);
    accept();

    // 6: mvi at 1023 takes immediate from address 0
    redirect_valid = 1'b1;
    redirect_pc    = 10'd1023;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    push_i(32'h08000007, 32'hAAAA5555, 10'd1023);
    wait_valid(n);
    chk("wrap_latency", 32'(n), 32'd3);
    chk("wrap_next_pc", 32'(mem_addr), 32'd1);
    accept();

    // Reset asserted asynchronously while in S_IMM
    redirect_valid = 1'b1;
    redirect_pc    = 10'd1023;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_instr_valid", 32'(instr_valid), 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_imm", imm, 32'h0);
    chk("arst_instr_pc", 32'(instr_pc), 32'h0);
    chk("arst_d_done", 32'(d_done), 32'h0);
    chk("arst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_i(32'hAAAA5555, 32'h0, 10'd0);
    wait_valid(n);
    chk("post_reset_latency", 32'(n), 32'd2);
    accept();

    repeat (3) @(posedge clk);
    #1;
    chk("instr_queue_empty", 32'(iq.size()), 32'd0);
    chk("data_queue_empty", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
